text_overlay_ctrl: RTL and testbench
====================================

// Module: text_overlay_ctrl
// PURPOSE
//  Sequences on-screen sentences for the VGA text path. It chooses which sentence code drives the
//  letter lookup's bgState, arbitrating game-event requests by priority. It performs a frame-timed
//  typewriter reveal by publishing a reveal limit: the letter path blanks any cell index above it.
//  Sits between game control FSM and the letter lookup/ROM stage; advances only on frame pulses.
// PARAMETERS
//  CHAR_FRAMES  2    frames per revealed cell (>=1)
//  HOLD_FRAMES  120  frames a non-sticky sentence stays fully shown before release (0 = forever)
//  MAX_INDEX    47   last cell index of any sentence; reveal stops here
//  BLINK_FRAMES 30   half-period of blink in frames (used only with TEXT_BLINK_EN)
// PORTS
//  clk          in   1  pixel/system clock
//  resetN       in   1  async active-low reset
//  startOfFrame in   1  one-cycle pulse per VGA frame
//  reqPrompt    in   1  pulse: request "press s to start" (code 1)
//  reqRandom    in   1  pulse: request "press space to randomize bricks" (code 2)
//  reqWin       in   1  pulse: request "you win" (code 3, sticky)
//  reqLose      in   1  pulse: request "you lose" (code 4, sticky)
//  clearReq     in   1  pulse: blank overlay, drop active and pending sentences
//  bgState      out  3  sentence code to letter lookup (0 = none)
//  revealLimit  out  7  highest cell index allowed visible
//  textOn       out  1  overlay enable (0 forces all letters blank)
//  busy         out  1  1 while REVEAL or HOLD
// BEHAVIOUR
//  - Reset: bgState=0, revealLimit=0, textOn=0, busy=0, state IDLE, pending=0, all counters 0.
//  - Reset mid-operation aborts immediately to these values; no request survives reset.
//  - Priority: lose(4) > win(3) > random(2) > prompt(1); multiple same-cycle pulses -> highest wins,
//    others discarded unless lower than active (then rule below).
//  - FSM IDLE -> REVEAL: on any request (or pending!=0) next cycle: bgState=code, revealLimit=0,
//    textOn=1, busy=1, frame counter cleared.
//  - REVEAL: each startOfFrame increments frame counter; at CHAR_FRAMES-th frame revealLimit+=1,
//    counter clears. Reaching MAX_INDEX -> HOLD on same cycle; revealLimit saturates, never wraps.
//  - HOLD: codes 3/4 stay indefinitely (sticky). Codes 1/2 count HOLD_FRAMES frames then go to
//    IDLE (bgState=0, textOn=0) or straight to REVEAL of pending if pending!=0.
//  - Request equal to active code: ignored, no restart.
//  - Higher-priority request while busy: preempt; next cycle REVEAL restarts at 0 with new code.
//  - Lower-priority request while busy: stored in 1-deep pending (higher pending overwrites lower).
//  - clearReq: highest precedence over everything incl. same-cycle requests; -> IDLE, pending=0.
//  - startOfFrame coincident with state entry is not counted (counter starts next frame).
//  - All outputs registered; request-to-bgState latency exactly 1 clk.
// CONFIGURATION
//  TEXT_BLINK_EN defined: in HOLD, textOn toggles every BLINK_FRAMES frames starting at 1.
//    textOn is forced 1 in REVEAL.
//  TEXT_BLINK_EN undefined: textOn = 1 whenever state != IDLE; no blink counter synthesized.
// STRUCTURE
//  - Package text_overlay_pkg: enum sentence_t {SENT_NONE=0, SENT_PROMPT=1, SENT_RANDOM=2,
//    SENT_WIN=3, SENT_LOSE=4} (3 bits).
//  - Also holds state_t {IDLE, REVEAL, HOLD}, function is_sticky(sentence_t), TEXT_IDX_W=7.
//  - Sub-module frame_tick_counter: counts startOfFrame, terminal-count input, clear input,
//    one-cycle done output.
//  - Instanced for reveal/hold timing and, under TEXT_BLINK_EN, for blink.
// TESTING
//  - Reset sequencing: reqPrompt, then resetN low mid-REVEAL -> all outputs 0 the same cycle.
//    After release, state stays IDLE.
//  - Reveal timing, CHAR_FRAMES=2: reqPrompt -> bgState=1 next clk.
//    revealLimit=1 after frame 2, =5 after frame 10, =47 after frame 94; busy=1.
//  - Hold release, HOLD_FRAMES=3, code 1: 3 frames after reaching HOLD -> bgState=0, textOn=0, busy=0.
//  - Arbitration: reqRandom and reqWin same clk -> bgState=3.
//    Then reqPrompt goes pending; win sticky, so prompt never shown until clearReq.
//    After clearReq -> IDLE; pending dropped.
//  - Preempt: during REVEAL of code 2 at revealLimit=10, reqLose -> next clk bgState=4, revealLimit=0.
//    A second reqLose is ignored.
//  - Blink (TEXT_BLINK_EN, BLINK_FRAMES=2): code 3 in HOLD -> textOn 1,1,0,0,1 over frames.
//    Undefined -> textOn constant 1.

Source files
------------

// File: rtl/text_overlay_pkg.sv
// Shared types for the text overlay sequencer: sentence codes, FSM states,
// cell index width and frame counter width.
package text_overlay_pkg;

   localparam int TEXT_IDX_W = 7;
   localparam int CNT_W      = 16;

   typedef enum logic [2:0] {
      SENT_NONE   = 3'd0,
      SENT_PROMPT = 3'd1,
      SENT_RANDOM = 3'd2,
      SENT_WIN    = 3'd3,
      SENT_LOSE   = 3'd4
   } sentence_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REVEAL = 2'd1,
      HOLD   = 2'd2
   } state_t;

   // Win/lose sentences stay on screen until cleared or preempted.
   function automatic logic is_sticky(input sentence_t code);
      return (code == SENT_WIN) || (code == SENT_LOSE);
   endfunction

endpackage

// File: rtl/text_overlay_ctrl_frame_tick_counter.sv
// Frame tick counter: counts startOfFrame pulses and raises done for one
// cycle on the tick that reaches term_count. A term_count of 0 never fires.
// done is combinational from tick so the owner acts on the frame's own edge.
module frame_tick_counter
   import text_overlay_pkg::*;
(
   input  logic             clk,
   input  logic             resetN,
   input  logic             tick,
   input  logic             clear,
   input  logic [CNT_W-1:0] term_count,
   output logic             done
);

   logic [CNT_W-1:0] count;

   assign done = tick && (term_count != '0) && (count == term_count - 1'b1);

   // count ticks; restart on clear or when the terminal count is reached
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         count <= '0;
      else if (clear || done)
         count <= '0;
      else if (tick)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/text_overlay_ctrl.sv
// Text overlay sequencer: arbitrates sentence requests by priority, reveals
// the chosen sentence one cell every CHAR_FRAMES frames, then holds it.
// Optional feature macro: TEXT_BLINK_EN (blinks textOn while holding).
//
//  state  | meaning
//  IDLE   | no sentence, overlay off
//  REVEAL | revealLimit advancing toward MAX_INDEX
//  HOLD   | fully shown; non-sticky codes released after HOLD_FRAMES
module text_overlay_ctrl
   import text_overlay_pkg::*;
#(
   parameter int CHAR_FRAMES  = 2,
   parameter int HOLD_FRAMES  = 120,
   parameter int MAX_INDEX    = 47,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  startOfFrame,
   input  logic                  reqPrompt,
   input  logic                  reqRandom,
   input  logic                  reqWin,
   input  logic                  reqLose,
   input  logic                  clearReq,
   output logic [2:0]            bgState,
   output logic [TEXT_IDX_W-1:0] revealLimit,
   output logic                  textOn,
   output logic                  busy
);

   localparam logic [TEXT_IDX_W-1:0] LAST_IDX = TEXT_IDX_W'(MAX_INDEX);

   if (CHAR_FRAMES < 1 || BLINK_FRAMES < 1) begin : g_bad_param
      $error("text_overlay_ctrl: CHAR_FRAMES and BLINK_FRAMES must be >= 1");
   end

   state_t                  state;
   sentence_t               active;
   sentence_t               pending;
   sentence_t               req_code;
   sentence_t               start_code;
   sentence_t               pend_in;
   logic [TEXT_IDX_W-1:0]   limit;
   logic                    busy_q;
   logic                    text_on;
   logic                    do_clear;
   logic                    do_start;
   logic                    reveal_end;
   logic                    hold_end;
   logic                    tick_done;
   logic                    ctr_clear;
   logic [CNT_W-1:0]        tick_tc;

   assign bgState     = active;
   assign revealLimit = limit;
   assign textOn      = text_on;
   assign busy        = busy_q;

   // highest-priority request this cycle
   always_comb begin
      if (reqLose)
         req_code = SENT_LOSE;
      else if (reqWin)
         req_code = SENT_WIN;
      else if (reqRandom)
         req_code = SENT_RANDOM;
      else if (reqPrompt)
         req_code = SENT_PROMPT;
      else
         req_code = SENT_NONE;
   end

   // event decisions in precedence order: clear, start/preempt, timers
   always_comb begin
      do_clear   = clearReq;
      do_start   = 1'b0;
      start_code = (req_code > pending) ? req_code : pending;
      pend_in    = pending;
      reveal_end = 1'b0;
      hold_end   = 1'b0;
      if (!do_clear) begin
         if (state == IDLE) begin
            do_start = (start_code != SENT_NONE);
         end else if (req_code > active) begin
            do_start   = 1'b1;
            start_code = req_code;
         end else begin
            if (req_code != SENT_NONE && req_code < active && req_code > pending)
               pend_in = req_code;
            if (state == REVEAL)
               reveal_end = tick_done && (limit == LAST_IDX - 1'b1);
            else
               hold_end = tick_done && !is_sticky(active);
         end
      end
   end

   assign ctr_clear = (state == IDLE) || do_clear || do_start || reveal_end || hold_end;
   assign tick_tc   = (state == HOLD) ? CNT_W'(HOLD_FRAMES) : CNT_W'(CHAR_FRAMES);

   frame_tick_counter u_tick (
      .clk        (clk),
      .resetN     (resetN),
      .tick       (startOfFrame),
      .clear      (ctr_clear),
      .term_count (tick_tc),
      .done       (tick_done)
   );

`ifdef TEXT_BLINK_EN
   logic blink_done;
   logic blink_clear;

   assign blink_clear = (state != HOLD) || do_clear || do_start || hold_end;

   frame_tick_counter u_blink (
      .clk        (clk),
      .resetN     (resetN),
      .tick       (startOfFrame),
      .clear      (blink_clear),
      .term_count (CNT_W'(BLINK_FRAMES)),
      .done       (blink_done)
   );
`endif

   // sequencer FSM with registered outputs
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state   <= IDLE;
         active  <= SENT_NONE;
         pending <= SENT_NONE;
         limit   <= '0;
         busy_q  <= 1'b0;
         text_on <= 1'b0;
      end else if (do_clear) begin
         state   <= IDLE;
         active  <= SENT_NONE;
         pending <= SENT_NONE;
         limit   <= '0;
         busy_q  <= 1'b0;
         text_on <= 1'b0;
      end else if (do_start) begin
         state   <= REVEAL;
         active  <= start_code;
         limit   <= '0;
         busy_q  <= 1'b1;
         text_on <= 1'b1;
         if (state == IDLE)
            pending <= SENT_NONE;
      end else if (reveal_end) begin
         state   <= HOLD;
         limit   <= LAST_IDX;
         pending <= pend_in;
         text_on <= 1'b1;
      end else if (hold_end) begin
         if (pend_in != SENT_NONE) begin
            state   <= REVEAL;
            active  <= pend_in;
            pending <= SENT_NONE;
            limit   <= '0;
            text_on <= 1'b1;
         end else begin
            state   <= IDLE;
            active  <= SENT_NONE;
            pending <= SENT_NONE;
            limit   <= '0;
            busy_q  <= 1'b0;
            text_on <= 1'b0;
         end
      end else begin
         pending <= pend_in;
         if (state == REVEAL && tick_done)
            limit <= limit + 1'b1;
`ifdef TEXT_BLINK_EN
         if (state == HOLD && blink_done)
            text_on <= !text_on;
`endif
      end
   end

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Bench for text_overlay_ctrl: directed scenarios plus random request
// traffic, all compared against a sentence-level reference model.
module tb_text_overlay_ctrl;

   localparam int CHAR  = 2;
   localparam int HOLD  = 3;
   localparam int MAX   = 47;
   localparam int BLINK = 2;

   logic       clk = 1'b0;
   logic       resetN;
   logic       startOfFrame, reqPrompt, reqRandom, reqWin, reqLose, clearReq;
   logic [2:0] bgState;
   logic [6:0] revealLimit;
   logic       textOn, busy;

   int errors = 0;
   int checks = 0;

   // reference model: shown sentence, cells revealed, frames since last event
   int m_code, m_shown, m_frames, m_pend, m_bcnt, m_on;

   always #5 clk = ~clk;

   text_overlay_ctrl #(
      .CHAR_FRAMES(CHAR), .HOLD_FRAMES(HOLD), .MAX_INDEX(MAX), .BLINK_FRAMES(BLINK)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .reqPrompt(reqPrompt), .reqRandom(reqRandom), .reqWin(reqWin), .reqLose(reqLose),
      .clearReq(clearReq), .bgState(bgState), .revealLimit(revealLimit),
      .textOn(textOn), .busy(busy)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_code = 0; m_shown = 0; m_frames = 0; m_pend = 0; m_bcnt = 0; m_on = 1;
   endtask

   function automatic int exp_text_on();
`ifdef TEXT_BLINK_EN
      return (m_code != 0 && (m_shown < MAX || m_on != 0)) ? 1 : 0;
`else
      return (m_code != 0) ? 1 : 0;
`endif
   endfunction

   task automatic model_step(input bit p, input bit r, input bit w, input bit l,
                             input bit c, input bit s);
      int req;
      bit released;
      req = l ? 4 : w ? 3 : r ? 2 : p ? 1 : 0;
      released = 1'b0;
      if (c) begin
         m_code = 0; m_pend = 0; m_shown = 0; m_frames = 0;
      end else if (req > m_code) begin
         if (m_code == 0) m_pend = 0;
         m_code = req; m_shown = 0; m_frames = 0;
      end else if (m_code != 0) begin
         if (req != 0 && req < m_code && req > m_pend) m_pend = req;
         if (s) begin
            if (m_shown < MAX) begin
               m_frames++;
               if (m_frames == CHAR) begin
                  m_frames = 0;
                  m_shown++;
                  if (m_shown == MAX) begin m_bcnt = 0; m_on = 1; end
               end
            end else begin
               if (m_code < 3 && HOLD != 0) begin
                  m_frames++;
                  if (m_frames == HOLD) begin
                     released = 1'b1;
                     m_frames = 0;
                     if (m_pend != 0) begin
                        m_code = m_pend; m_pend = 0; m_shown = 0;
                     end else begin
                        m_code = 0; m_shown = 0;
                     end
                  end
               end
               if (!released) begin
                  m_bcnt++;
                  if (m_bcnt == BLINK) begin m_bcnt = 0; m_on = (m_on != 0) ? 0 : 1; end
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("bgState", int'(bgState), m_code);
      chk("revealLimit", int'(revealLimit), m_shown);
      chk("textOn", int'(textOn), exp_text_on());
      chk("busy", int'(busy), (m_code != 0) ? 1 : 0);
   endtask

   // called at a negedge: check, drive the next inputs, advance one clock
   task automatic step(input bit p, input bit r, input bit w, input bit l,
                       input bit c, input bit s);
      compare_all();
      reqPrompt = p; reqRandom = r; reqWin = w; reqLose = l; clearReq = c; startOfFrame = s;
      model_step(p, r, w, l, c, s);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         step(0, 0, 0, 0, 0, 1);
         step(0, 0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      resetN = 1'b0;
      {startOfFrame, reqPrompt, reqRandom, reqWin, reqLose, clearReq} = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_bg", int'(bgState), 0);
      chk("rst_lim", int'(revealLimit), 0);
      chk("rst_text", int'(textOn), 0);
      chk("rst_busy", int'(busy), 0);
      resetN = 1'b1;

      // reset mid-REVEAL
      step(1, 0, 0, 0, 0, 0);
      frames(7);
      resetN = 1'b0;
      #1;
      chk("midrst_bg", int'(bgState), 0);
      chk("midrst_lim", int'(revealLimit), 0);
      chk("midrst_text", int'(textOn), 0);
      chk("midrst_busy", int'(busy), 0);
      model_reset();
      @(negedge clk);
      resetN = 1'b1;
      frames(5);
      chk("postrst_idle", int'(busy), 0);

      // reveal timing and hold release
      step(1, 0, 0, 0, 0, 0);
      chk("rev_bg", int'(bgState), 1);
      for (int f = 1; f <= 94; f++) begin
         step(0, 0, 0, 0, 0, 1);
         if (f == 2)  chk("rev_lim_f2", int'(revealLimit), 1);
         if (f == 10) chk("rev_lim_f10", int'(revealLimit), 5);
         if (f == 94) chk("rev_lim_f94", int'(revealLimit), 47);
         chk("rev_busy", int'(busy), 1);
         step(0, 0, 0, 0, 0, 0);
      end
      frames(2);
      chk("hold_still_bg", int'(bgState), 1);
      step(0, 0, 0, 0, 0, 1);
      chk("hold_rel_bg", int'(bgState), 0);
      chk("hold_rel_text", int'(textOn), 0);
      chk("hold_rel_busy", int'(busy), 0);

      // arbitration, sticky win, pending prompt dropped by clear
      step(0, 1, 1, 0, 0, 0);
      chk("arb_bg", int'(bgState), 3);
      step(1, 0, 0, 0, 0, 0);
      frames(110);
      chk("sticky_bg", int'(bgState), 3);
      chk("sticky_lim", int'(revealLimit), 47);
      step(0, 0, 0, 0, 1, 0);
      chk("clr_bg", int'(bgState), 0);
      frames(6);
      chk("clr_pend_dropped", int'(bgState), 0);

      // preempt during reveal
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 200 && m_shown < 10; i++) step(0, 0, 0, 0, 0, 1);
      chk("pre_lim", int'(revealLimit), 10);
      step(0, 0, 0, 1, 0, 0);
      chk("pre_bg", int'(bgState), 4);
      chk("pre_lim0", int'(revealLimit), 0);
      frames(3);
      step(0, 0, 0, 1, 0, 0);
      chk("pre_again_bg", int'(bgState), 4);
      chk("pre_again_lim", int'(revealLimit), 1);
      step(0, 0, 0, 0, 1, 0);

      // random traffic
      for (int i = 0; i < 30000; i++) begin
         step($urandom_range(0, 399) == 0, $urandom_range(0, 399) == 0,
              $urandom_range(0, 599) == 0, $urandom_range(0, 599) == 0,
              $urandom_range(0, 2999) == 0, $urandom_range(0, 2) == 0);
      end
      compare_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
